bp_dma_axil_sequencer: RTL and testbench

Sequences bsg_cache DMA traffic from the unicore L2 onto the single 64-bit AXI4-Lite memory port of the MIG subsystem, running in the 20 MHz AXI clock domain. Each DMA packet is one cache block. The block breaks it into single-beat AXI4-Lite transactions at consecutive 8-byte addresses, one transaction in flight at a time. Read data is returned on the DMA data-out channel; DMA write data is drained onto AW/W with B acknowledgement.

---
 rtl/bp_dma_axil_sequencer_if.sv | 41 ++++
 rtl/bp_dma_axil_sequencer.sv | 157 +++++++++++++++
 tb/tb_bp_dma_axil_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_dma_axil_sequencer_if.sv
// rtl/bp_dma_axil_sequencer_if.sv - single-port AXI4-Lite bus between the DMA sequencer (master) and memory (slave)
interface bp_dma_axil_sequencer_if #(
  parameter int addr_width_p = 28,
  parameter int data_width_p = 64
);
  logic [addr_width_p-1:0]   araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [data_width_p-1:0]   rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;
  logic [addr_width_p-1:0]   awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [data_width_p-1:0]   wdata;
  logic [data_width_p/8-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;

  modport master (
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/bp_dma_axil_sequencer.sv
// rtl/bp_dma_axil_sequencer.sv - splits cache-block DMA packets into single-beat AXI4-Lite transfers
// Optional sticky response-error flags: define BP_DMA_AXIL_ERR_CHECK_EN.
module bp_dma_axil_sequencer #(
  parameter int daddr_width_p     = 28,
  parameter int axil_addr_width_p = 28,
  parameter int block_width_p     = 512,
  parameter int fill_width_p      = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [daddr_width_p:0]     dma_pkt_i,
  input  logic                       dma_pkt_v_i,
  output logic                       dma_pkt_yumi_o,
  output logic [fill_width_p-1:0]    dma_data_o,
  output logic                       dma_data_v_o,
  input  logic                       dma_data_ready_and_i,
  input  logic [fill_width_p-1:0]    dma_data_i,
  input  logic                       dma_data_v_i,
  output logic                       dma_data_yumi_o,
  bp_dma_axil_sequencer_if.master    axil,
  output logic                       rd_error_o,
  output logic                       wr_error_o,
  output logic                       busy_o
);
  localparam int n_lp        = block_width_p / fill_width_p;
  localparam int lg_n_lp     = $clog2(n_lp);
  localparam int blk_off_lp  = $clog2(block_width_p / 8);
  localparam int beat_off_lp = $clog2(fill_width_p / 8);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, RD_OUT, WR_DATA, WR_REQ, WR_B} state_e;

  state_e                         state_q, state_d;
  logic [lg_n_lp-1:0]             beat_q, beat_d;
  logic [axil_addr_width_p-1:0]   base_q, base_d;
  logic [fill_width_p-1:0]        rdata_q, rdata_d;
  logic [fill_width_p-1:0]        wdata_q, wdata_d;
  logic                           aw_done_q, aw_done_d;
  logic                           w_done_q, w_done_d;

  logic                           last_beat;
  logic [axil_addr_width_p-1:0]   pkt_addr_ext;
  logic [axil_addr_width_p-1:0]   beat_addr;

  assign last_beat    = (beat_q == lg_n_lp'(n_lp - 1));
  assign pkt_addr_ext = axil_addr_width_p'(dma_pkt_i[daddr_width_p-1:0]);
  assign beat_addr    = base_q + axil_addr_width_p'({beat_q, {beat_off_lp{1'b0}}});

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      base_q    <= '0;
      rdata_q   <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      rdata_q   <= rdata_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (dma_pkt_v_i) state_d = dma_pkt_i[daddr_width_p] ? WR_DATA : RD_AR;
      RD_AR:   if (axil.arready) state_d = RD_R;
      RD_R:    if (axil.rvalid) state_d = RD_OUT;
      RD_OUT:  if (dma_data_ready_and_i) state_d = last_beat ? IDLE : RD_AR;
      WR_DATA: if (dma_data_v_i) state_d = WR_REQ;
      WR_REQ:  if ((aw_done_q | axil.awready) & (w_done_q | axil.wready)) state_d = WR_B;
      WR_B:    if (axil.bvalid) state_d = last_beat ? IDLE : WR_DATA;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state; AW and W completion are tracked separately so either may finish first.
  always_comb begin
    beat_d    = beat_q;
    base_d    = base_q;
    rdata_d   = rdata_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      IDLE: if (dma_pkt_v_i) begin
        base_d = {pkt_addr_ext[axil_addr_width_p-1:blk_off_lp], {blk_off_lp{1'b0}}};
        beat_d = '0;
      end
      RD_R:    if (axil.rvalid) rdata_d = axil.rdata;
      RD_OUT:  if (dma_data_ready_and_i) beat_d = beat_q + lg_n_lp'(1);
      WR_DATA: if (dma_data_v_i) begin
        wdata_d   = dma_data_i;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
      WR_REQ: begin
        aw_done_d = aw_done_q | axil.awready;
        w_done_d  = w_done_q | axil.wready;
      end
      WR_B:    if (axil.bvalid) beat_d = beat_q + lg_n_lp'(1);
      default: ;
    endcase
  end

  always_comb begin
    dma_pkt_yumi_o  = (state_q == IDLE) & dma_pkt_v_i & ~reset_i;
    dma_data_v_o    = (state_q == RD_OUT);
    dma_data_yumi_o = (state_q == WR_DATA) & dma_data_v_i;
    axil.arvalid    = (state_q == RD_AR);
    axil.rready     = (state_q == RD_R);
    axil.awvalid    = (state_q == WR_REQ) & ~aw_done_q;
    axil.wvalid     = (state_q == WR_REQ) & ~w_done_q;
    axil.bready     = (state_q == WR_B);
    busy_o          = (state_q != IDLE);
  end

  assign dma_data_o  = rdata_q;
  assign axil.araddr = beat_addr;
  assign axil.awaddr = beat_addr;
  assign axil.arprot = 3'b000;
  assign axil.awprot = 3'b000;
  assign axil.wdata  = wdata_q;
  assign axil.wstrb  = '1;

`ifdef BP_DMA_AXIL_ERR_CHECK_EN
  logic rd_err_q, rd_err_d, wr_err_q, wr_err_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_err_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      rd_err_q <= rd_err_d;
      wr_err_q <= wr_err_d;
    end
  end

  always_comb begin
    rd_err_d = rd_err_q | ((state_q == RD_R) & axil.rvalid & (axil.rresp != 2'b00));
    wr_err_d = wr_err_q | ((state_q == WR_B) & axil.bvalid & (axil.bresp != 2'b00));
  end

  assign rd_error_o = rd_err_q;
  assign wr_error_o = wr_err_q;
`else
  wire unused_resp = ^{axil.rresp, axil.bresp};

  assign rd_error_o = 1'b0;
  assign wr_error_o = 1'b0;
`endif
endmodule

// File: tb/tb_bp_dma_axil_sequencer.sv
// tb/tb_bp_dma_axil_sequencer.sv - randomized bench for bp_dma_axil_sequencer against a beat-level model
module tb_bp_dma_axil_sequencer;
`ifdef BP_DMA_AXIL_ERR_CHECK_EN
  localparam bit err_en_lp = 1'b1;
`else
  localparam bit err_en_lp = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [28:0] dma_pkt_i;
  logic        dma_pkt_v_i;
  logic        dma_pkt_yumi_o;
  logic [63:0] dma_data_o;
  logic        dma_data_v_o;
  logic        dma_data_ready_and_i;
  logic [63:0] dma_data_i;
  logic        dma_data_v_i;
  logic        dma_data_yumi_o;
  logic        rd_error_o, wr_error_o, busy_o;

  bp_dma_axil_sequencer_if #(.addr_width_p(28), .data_width_p(64)) axil ();

  bp_dma_axil_sequencer dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_ready_and_i(dma_data_ready_and_i),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
    .axil(axil),
    .rd_error_o(rd_error_o), .wr_error_o(wr_error_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] beat_data [8];
  bit          rd_err_exp = 1'b0;
  bit          wr_err_exp = 1'b0;
  int          err_rate = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] beat_addr(input logic [27:0] addr, input int i);
    return ((64'(addr) & ~64'h3F) + 64'(8 * i)) & 64'h0FFF_FFFF;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_arvalid"}, axil.arvalid, 0);
    chk({tag, "_rready"}, axil.rready, 0);
    chk({tag, "_awvalid"}, axil.awvalid, 0);
    chk({tag, "_wvalid"}, axil.wvalid, 0);
    chk({tag, "_bready"}, axil.bready, 0);
    chk({tag, "_pkt_yumi"}, dma_pkt_yumi_o, 0);
    chk({tag, "_data_v"}, dma_data_v_o, 0);
    chk({tag, "_data_yumi"}, dma_data_yumi_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_dma_data"}, dma_data_o, 0);
    chk({tag, "_araddr"}, axil.araddr, 0);
    chk({tag, "_awaddr"}, axil.awaddr, 0);
    chk({tag, "_wdata"}, axil.wdata, 0);
    chk({tag, "_rd_err"}, rd_error_o, 0);
    chk({tag, "_wr_err"}, wr_error_o, 0);
  endtask

  task automatic do_read(input logic [27:0] addr, input int stall_beat, input int stall_len, input int abort_beat);
    logic [63:0] ea;
    logic [1:0]  rr;
    int          d;
    @(negedge clk_i);
    dma_pkt_v_i = 1'b1;
    dma_pkt_i   = {1'b0, addr};
    #1 chk("rd_pkt_yumi", dma_pkt_yumi_o, 1);
    @(negedge clk_i);
    dma_pkt_v_i = 1'b0;
    dma_pkt_i   = '0;
    for (int i = 0; i < 8; i++) begin
      ea = beat_addr(addr, i);
      d  = $urandom_range(0, 2);
      for (int k = 0; k < d; k++) begin
        #1 chk("arvalid_wait", axil.arvalid, 1);
        chk("araddr_wait", axil.araddr, ea);
        @(negedge clk_i);
      end
      axil.arready = 1'b1;
      #1 chk("arvalid", axil.arvalid, 1);
      chk("araddr", axil.araddr, ea);
      chk("arprot", axil.arprot, 0);
      @(negedge clk_i);
      axil.arready = 1'b0;
      if (i == abort_beat) begin
        #1 chk("rready_pre_rst", axil.rready, 1);
        reset_i = 1'b1;
        #1 chk_all_zero("rst_mid");
        rd_err_exp = 1'b0;
        wr_err_exp = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b0;
        return;
      end
      d = $urandom_range(0, 2);
      for (int k = 0; k < d; k++) begin
        #1 chk("rready_wait", axil.rready, 1);
        chk("data_v_early", dma_data_v_o, 0);
        @(negedge clk_i);
      end
      rr = ($urandom_range(0, 99) < err_rate) ? 2'b10 : 2'b00;
      axil.rvalid = 1'b1;
      axil.rdata  = beat_data[i];
      axil.rresp  = rr;
      #1 chk("rready", axil.rready, 1);
      @(negedge clk_i);
      axil.rvalid = 1'b0;
      axil.rdata  = $urandom();
      axil.rresp  = 2'b00;
      if (err_en_lp && rr != 2'b00) rd_err_exp = 1'b1;
      d = (i == stall_beat) ? stall_len : $urandom_range(0, 2);
      for (int k = 0; k < d; k++) begin
        #1 chk("data_v_hold", dma_data_v_o, 1);
        chk("dma_data_hold", dma_data_o, beat_data[i]);
        chk("no_ar_in_out", axil.arvalid, 0);
        @(negedge clk_i);
      end
      dma_data_ready_and_i = 1'b1;
      #1 chk("data_v", dma_data_v_o, 1);
      chk("dma_data", dma_data_o, beat_data[i]);
      chk("rd_error", rd_error_o, rd_err_exp);
      @(negedge clk_i);
      dma_data_ready_and_i = 1'b0;
    end
    #1 chk("rd_busy_end", busy_o, 0);
  endtask

  task automatic do_write(input logic [27:0] addr, input int aw_fix, input int w_fix, input int err_beat);
    logic [63:0] ea;
    logic [1:0]  br;
    int          d, a, w, m;
    @(negedge clk_i);
    dma_pkt_v_i = 1'b1;
    dma_pkt_i   = {1'b1, addr};
    #1 chk("wr_pkt_yumi", dma_pkt_yumi_o, 1);
    @(negedge clk_i);
    dma_pkt_v_i = 1'b0;
    dma_pkt_i   = '0;
    for (int i = 0; i < 8; i++) begin
      ea = beat_addr(addr, i);
      d  = $urandom_range(0, 2);
      for (int k = 0; k < d; k++) begin
        #1 chk("data_yumi_idle", dma_data_yumi_o, 0);
        chk("awvalid_idle", axil.awvalid, 0);
        @(negedge clk_i);
      end
      dma_data_v_i = 1'b1;
      dma_data_i   = beat_data[i];
      #1 chk("data_yumi", dma_data_yumi_o, 1);
      @(negedge clk_i);
      dma_data_v_i = 1'b0;
      dma_data_i   = $urandom();
      a = (aw_fix >= 0) ? aw_fix : $urandom_range(0, 3);
      w = (w_fix >= 0) ? w_fix : $urandom_range(0, 3);
      m = (a > w) ? a : w;
      for (int c = 0; c <= m; c++) begin
        axil.awready = (c == a);
        axil.wready  = (c == w);
        #1 chk("awvalid", axil.awvalid, (c <= a));
        chk("wvalid", axil.wvalid, (c <= w));
        if (c <= a) chk("awaddr", axil.awaddr, ea);
        if (c <= w) chk("wdata", axil.wdata, beat_data[i]);
        if (c == 0) chk("wstrb", axil.wstrb, 8'hFF);
        @(negedge clk_i);
      end
      axil.awready = 1'b0;
      axil.wready  = 1'b0;
      d = $urandom_range(0, 2);
      for (int k = 0; k < d; k++) begin
        #1 chk("bready_wait", axil.bready, 1);
        @(negedge clk_i);
      end
      if (i == err_beat) br = 2'b10;
      else br = ($urandom_range(0, 99) < err_rate) ? 2'b11 : 2'b00;
      axil.bvalid = 1'b1;
      axil.bresp  = br;
      #1 chk("bready", axil.bready, 1);
      @(negedge clk_i);
      axil.bvalid = 1'b0;
      axil.bresp  = 2'b00;
      if (err_en_lp && br != 2'b00) wr_err_exp = 1'b1;
      #1 chk("wr_error", wr_error_o, wr_err_exp);
    end
    #1 chk("wr_busy_end", busy_o, 0);
  endtask

  task automatic rand_data();
    for (int i = 0; i < 8; i++) beat_data[i] = {$urandom(), $urandom()};
  endtask

  initial begin
    reset_i = 1'b1;
    dma_pkt_i = '0;
    dma_pkt_v_i = 1'b1;
    dma_data_ready_and_i = 1'b0;
    dma_data_i = '0;
    dma_data_v_i = 1'b0;
    axil.arready = 1'b0; axil.rdata = '0; axil.rresp = '0; axil.rvalid = 1'b0;
    axil.awready = 1'b0; axil.wready = 1'b0; axil.bresp = '0; axil.bvalid = 1'b0;
    repeat (3) @(negedge clk_i);
    #1 chk_all_zero("reset");
    dma_pkt_v_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;

    for (int i = 0; i < 8; i++) beat_data[i] = 64'hA0 + 64'(i);
    do_read(28'h0001040, -1, 0, -1);

    rand_data();
    do_write(28'h0002000, 0, 3, -1);

    rand_data();
    do_read(28'h0003000, 2, 5, -1);

    rand_data();
    do_read(28'h0FFFFFFC, -1, 0, -1);

    rand_data();
    do_write(28'h0004000, -1, -1, 4);

    rand_data();
    do_read(28'h0005000, -1, 0, 3);
    rand_data();
    do_read(28'h0006000, -1, 0, -1);

    err_rate = 20;
    for (int p = 0; p < 8; p++) begin
      rand_data();
      if ($urandom_range(0, 1) == 0) do_read(28'($urandom()), -1, 0, -1);
      else do_write(28'($urandom()), -1, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
